// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, default rates and helper functions
package uart_pkg;
  localparam int CLK_FREQ_DEF = 100_000_000;
  localparam int BAUD_RATE_DEF = 19200;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  function automatic int bit_cycles(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction
  function automatic logic par(input logic [7:0] data, input logic odd);
    return odd ? ~^data : ^data;
  endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: one-cycle bit_tick every BIT_CYCLES clocks, with synchronous clear
module uart_baud_gen #(
  parameter int BIT_CYCLES = 5208,
  localparam int W = $clog2(BIT_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_tick
);
  logic [W-1:0] cnt;
  assign bit_tick = cnt == W'(BIT_CYCLES - 1);
  // count clocks within a bit period, restarting on clear or at the period end
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (clr || bit_tick) ? '0 : cnt + W'(1);
endmodule

// File: rtl/uart_tx_core.sv
// uart_tx_core: 8-bit data, parity, 1-stop UART transmitter
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = CLK_FREQ_DEF,
  parameter int BAUD_RATE = BAUD_RATE_DEF,
  parameter int PARITY_ODD = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic [7:0] din,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);
  localparam int BIT_CYCLES = bit_cycles(CLK_FREQ, BAUD_RATE);
  state_t state, state_n;
  logic [7:0] data, data_n;
  logic [2:0] idx, idx_n;
  logic par_q, par_n, tx_n, busy_n, done_n, bit_tick;
  uart_baud_gen #(.BIT_CYCLES(BIT_CYCLES)) u_baud (
    .clk(clk),
    .rst(rst),
    .clr(state == IDLE),
    .bit_tick(bit_tick)
  );
  // state and registered outputs; tx comes straight from a flop so it never glitches
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      data <= '0;
      idx <= '0;
      par_q <= 1'b0;
      tx <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state <= state_n;
      data <= data_n;
      idx <= idx_n;
      par_q <= par_n;
      tx <= tx_n;
      tx_busy <= busy_n;
      tx_done <= done_n;
    end
  // frame sequencing: data is shifted right so the next bit to send is always data[1]
  always_comb begin
    state_n = state;
    data_n = data;
    idx_n = idx;
    par_n = par_q;
    tx_n = tx;
    busy_n = tx_busy;
    done_n = 1'b0;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        busy_n = 1'b0;
        if (send) begin
          data_n = din;
          par_n = par(din, PARITY_ODD != 0);
          state_n = START;
          tx_n = 1'b0;
          busy_n = 1'b1;
        end
      end
      START:
        if (bit_tick) begin
          state_n = DATA;
          idx_n = '0;
          tx_n = data[0];
        end
      DATA:
        if (bit_tick) begin
          state_n = idx == 3'd7 ? PARITY : DATA;
          tx_n = idx == 3'd7 ? par_q : data[1];
          data_n = {1'b0, data[7:1]};
          idx_n = idx + 3'd1;
        end
      PARITY:
        if (bit_tick) begin
          state_n = STOP;
          tx_n = 1'b1;
        end
      STOP:
        if (bit_tick) begin
          state_n = IDLE;
          busy_n = 1'b0;
          done_n = 1'b1;
        end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: directed self-checking bench for uart_tx_core at 16 clocks per bit
module tb_uart_tx_core;
  localparam int BC = 16;
  localparam int N = 50;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic send = 1'b0;
  logic [7:0] din = '0;
  logic tx, tx_busy, tx_done;
  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;

  uart_tx_core #(.CLK_FREQ(160), .BAUD_RATE(10), .PARITY_ODD(1)) dut (
    .clk(clk),
    .rst(rst),
    .send(send),
    .din(din),
    .tx(tx),
    .tx_busy(tx_busy),
    .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (tx_done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic go(input logic [7:0] b);
    din = b;
    send = 1'b1;
    step(1);
    send = 1'b0;
  endtask

  // entered half a cycle after the accepting edge; samples each bit at its midpoint
  task automatic frame(input string tag, input logic [7:0] b, input logic p, input bit inj);
    check({tag, " tx_fall"}, 32'(tx), 0);
    check({tag, " busy_rise"}, 32'(tx_busy), 1);
    step(BC / 2);
    check({tag, " start"}, 32'(tx), 0);
    for (int i = 0; i < 8; i++) begin
      step(BC);
      check($sformatf("%s d%0d", tag, i), 32'(tx), 32'(b[i]));
      if (inj && i == 3) begin
        din = 8'h3C;
        send = 1'b1;
      end
      if (inj && i == 4) send = 1'b0;
    end
    step(BC);
    check({tag, " parity"}, 32'(tx), 32'(p));
    step(BC);
    check({tag, " stop"}, 32'(tx), 1);
    step(BC / 2 - 1);
    check({tag, " busy_last"}, {30'd0, tx_busy, tx_done}, 32'b10);
    step(1);
    check({tag, " done"}, {30'd0, tx_busy, tx_done}, 32'b01);
    step(1);
    check({tag, " done_clr"}, 32'(tx_done), 0);
  endtask

  initial begin
    int ok, cnt0, t, valid, perr;
    logic [7:0] bytes [N];
    logic [7:0] r;
    logic p, s;
    step(1);
    check("rst tx", 32'(tx), 1);
    check("rst busy", 32'(tx_busy), 0);
    check("rst done", 32'(tx_done), 0);
    step(2);
    rst = 1'b0;
    ok = 1;
    for (int i = 0; i < 1000; i++) begin
      step(1);
      if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) ok = 0;
    end
    check("idle 1000", ok, 1);

    go(8'h55); frame("x55", 8'h55, 1'b1, 0);
    go(8'h00); frame("x00", 8'h00, 1'b1, 0);
    go(8'h01); frame("x01", 8'h01, 1'b0, 0);
    go(8'hFF); frame("xFF", 8'hFF, 1'b1, 0);
    go(8'h80); frame("x80", 8'h80, 1'b0, 0);

    cnt0 = done_cnt;
    go(8'hA3); frame("busy xA3", 8'hA3, 1'b1, 1);
    step(2 * BC);
    check("busy reject idle", 32'(tx_busy), 0);
    check("busy reject one done", done_cnt - cnt0, 1);

    go(8'hC6);
    step(BC / 2 + 5 * BC);
    check("pre-rst d4", 32'(tx), 0);
    #2 rst = 1'b1;
    #1 check("async rst tx", 32'(tx), 1);
    check("async rst busy", 32'(tx_busy), 0);
    @(negedge clk);
    step(2);
    rst = 1'b0;
    step(1);
    check("post-rst idle", {30'd0, tx, tx_busy}, 32'b10);
    go(8'h0F); frame("x0F", 8'h0F, 1'b1, 0);

    for (int k = 0; k < N; k++) bytes[k] = 8'($urandom_range(0, 255));
    valid = 0;
    perr = 0;
    din = bytes[0];
    send = 1'b1;
    for (int k = 0; k < N; k++) begin
      t = 0;
      while (tx !== 1'b0 && t < 20 * BC) begin
        step(1);
        t++;
      end
      check($sformatf("lb%0d start", k), 32'(tx), 0);
      din = k < N - 1 ? bytes[k + 1] : 8'h00;
      if (k == N - 1) send = 1'b0;
      step(BC / 2);
      for (int i = 0; i < 8; i++) begin
        step(BC);
        r[i] = tx;
      end
      step(BC);
      p = tx;
      step(BC);
      s = tx;
      if (s === 1'b1) valid++;
      if ((^r ^ p) !== 1'b1) perr++;
      check($sformatf("lb%0d byte", k), 32'(r), 32'(bytes[k]));
    end
    check("lb valid count", valid, N);
    check("lb parity errors", perr, 0);
    step(2 * BC);
    check("lb end idle", 32'(tx_busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
